des_perm_pipe: RTL

Pipelined, parametrised DES permutation unit covering both the Initial Permutation (IP) and the Final Permutation (FP). It accepts one 64-bit block per cycle over a valid/ready handshake and applies the optional L/R half swap before FP. It carries a sideband tag and counts completed blocks. It sits between the round datapath and the block I/O, replacing the bare combinational FP with a stallable, registered stage that can also serve the input-side IP.

---
 rtl/des_perm_pipe.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/des_perm_pipe.sv
// des_perm_pipe: stallable, registered DES Initial/Final Permutation unit.
//
// A block {in_left, in_right} accepted on the valid/ready handshake is
// permuted (IP or FP, with the optional R||L swap before FP) as pure wiring
// and captured into stage 1. Stages 2..STAGES only delay the data, the tag
// and a valid bit. Empty stages are filled even while the output is stalled,
// so the pipe holds up to STAGES blocks.
//
// Parameters:
//   STAGES  register stages, 1..4
//   TAG_W   sideband tag width
//   CNT_W   completed-block counter width
//
// Ports:
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready  input handshake (in_ready has no path from in_valid)
//   in_mode              0 = FP, 1 = IP
//   in_swap              FP only: permute {in_right, in_left}
//   in_left, in_right    block halves (bits 63:32 and 31:0)
//   in_tag               sideband tag, passed through unchanged
//   out_valid/out_ready  output handshake
//   out_data, out_tag    last-stage registers, bit 63 = DES bit 1
//   out_count            completed output handshakes, wraps
//   cnt_clr              synchronous clear of out_count, wins over increment
//   err_sticky           self-check mismatch flag
//
// Build option: define DES_PERM_SELFCHECK_EN to carry the pre-permutation
// word through the pipe and check the inverse permutation of out_data
// against it. Without it err_sticky is tied to 0.

module des_perm_pipe #(
  parameter int STAGES = 2,
  parameter int TAG_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic             in_swap,
  input  logic [31:0]      in_left,
  input  logic [31:0]      in_right,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] out_count,
  input  logic             cnt_clr,
  output logic             err_sticky
);

  localparam int LAST = STAGES - 1;

  // Output bit i (0 = MSB = DES bit 1) takes DES input bit src. The IP and
  // FP tables are regular enough to be generated from row/column indices.
  function automatic logic [63:0] perm_ip(input logic [63:0] x);
    logic [63:0] y;
    int row, col, src;
    y = '0;
    for (int i = 0; i < 64; i++) begin
      row = i / 8;
      col = i % 8;
      src = ((row < 4) ? (58 + 2 * row) : (49 + 2 * row)) - 8 * col;
      y[6'(63 - i)] = x[6'(64 - src)];
    end
    return y;
  endfunction

  function automatic logic [63:0] perm_fp(input logic [63:0] x);
    logic [63:0] y;
    int row, col, src;
    y = '0;
    for (int i = 0; i < 64; i++) begin
      row = i / 8;
      col = i % 8;
      src = (((col % 2) == 0) ? 40 : 8) + 8 * (col / 2) - row;
      y[6'(63 - i)] = x[6'(64 - src)];
    end
    return y;
  endfunction

  logic [63:0]       in_word;
  logic [63:0]       perm_word;
  logic [STAGES-1:0] stage_ld;
  logic [STAGES-1:0] vld_q, vld_d;
  logic [63:0]       data_q [STAGES];
  logic [63:0]       data_d [STAGES];
  logic [TAG_W-1:0]  tag_q  [STAGES];
  logic [TAG_W-1:0]  tag_d  [STAGES];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              fire;

  assign in_word   = (!in_mode && in_swap) ? {in_right, in_left} : {in_left, in_right};
  assign perm_word = in_mode ? perm_ip(in_word) : perm_fp(in_word);

  // Stage k may load unless it and every stage after it are full while the
  // output is stalled. Scanning from the output keeps in_ready free of any
  // path from in_valid.
  always_comb begin
    logic tail_full;
    tail_full = 1'b1;
    stage_ld  = '0;
    for (int k = LAST; k >= 0; k--) begin
      tail_full   = tail_full & vld_q[k];
      stage_ld[k] = ~tail_full | out_ready;
    end
  end

  // NOTE: every variable written here gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    tag_d  = tag_q;
    if (stage_ld[0]) begin
      vld_d[0] = in_valid;
      if (in_valid) begin
        data_d[0] = perm_word;
        tag_d[0]  = in_tag;
      end
    end
    for (int k = 1; k < STAGES; k++) begin
      if (stage_ld[k]) begin
        vld_d[k] = vld_q[k-1];
        // Payload moves only with a real block so a bubble never disturbs it.
        if (vld_q[k-1]) begin
          data_d[k] = data_q[k-1];
          tag_d[k]  = tag_q[k-1];
        end
      end
    end
  end

  assign fire = vld_q[LAST] & out_ready;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (fire) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: the stage data/tag arrays are reset too, because out_data and
  // out_tag must read 0 during reset, not just be qualified by out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      cnt_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= '0;
        tag_q[k]  <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every stage samples the pre-edge
      // value of its neighbour.
      vld_q  <= vld_d;
      data_q <= data_d;
      tag_q  <= tag_d;
      cnt_q  <= cnt_d;
    end
  end

  assign in_ready  = stage_ld[0];
  assign out_valid = vld_q[LAST];
  assign out_data  = data_q[LAST];
  assign out_tag   = tag_q[LAST];
  assign out_count = cnt_q;

`ifdef DES_PERM_SELFCHECK_EN
  logic [63:0]       raw_q [STAGES];
  logic [63:0]       raw_d [STAGES];
  logic [STAGES-1:0] mode_q, mode_d;
  logic [STAGES-1:0] swap_q, swap_d;
  logic [63:0]       chk_word;
  logic [63:0]       chk_ref;
  logic              err_q, err_d;

  // Shadow pipe of the unpermuted halves and mode bits, moving in lockstep
  // with the main stages. The check on the last stage is combinational, so
  // it adds no latency.
  always_comb begin
    raw_d  = raw_q;
    mode_d = mode_q;
    swap_d = swap_q;
    if (stage_ld[0] && in_valid) begin
      raw_d[0]  = {in_left, in_right};
      mode_d[0] = in_mode;
      swap_d[0] = in_swap;
    end
    for (int k = 1; k < STAGES; k++) begin
      if (stage_ld[k] && vld_q[k-1]) begin
        raw_d[k]  = raw_q[k-1];
        mode_d[k] = mode_q[k-1];
        swap_d[k] = swap_q[k-1];
      end
    end
    chk_word = mode_q[LAST] ? perm_fp(data_q[LAST]) : perm_ip(data_q[LAST]);
    chk_ref  = (!mode_q[LAST] && swap_q[LAST]) ?
               {raw_q[LAST][31:0], raw_q[LAST][63:32]} : raw_q[LAST];
    err_d    = err_q | (vld_q[LAST] & (chk_word != chk_ref));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= '0;
      swap_q <= '0;
      err_q  <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        raw_q[k] <= '0;
      end
    end else begin
      raw_q  <= raw_d;
      mode_q <= mode_d;
      swap_q <= swap_d;
      err_q  <= err_d;
    end
  end

  assign err_sticky = err_q;
`else
  assign err_sticky = 1'b0;
`endif

endmodule
